// File: rtl/reg_bus_pkg.sv
// Purpose: shared address map, CTRL/STATUS bit positions and CTRL layout for reg_bus_slave.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package reg_bus_pkg;

  // Register addresses
  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h01;
  localparam logic [7:0] ADDR_DATA    = 8'h02;
  localparam logic [7:0] ADDR_SCRATCH = 8'h03;

  // CTRL bit indices
  localparam int CTRL_DRAIN_EN = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_FLUSH    = 2;

  // STATUS bit indices
  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_OVERFLOW = 2;
  localparam int STAT_CNT_LSB  = 4;

  // CTRL as stored. flush and rsvd are never stored as 1, so the whole
  // struct can be returned verbatim on a CTRL read.
  typedef struct packed {
    logic [4:0] rsvd;
    logic       flush;
    logic       irq_en;
    logic       drain_en;
  } ctrl_t;

  // STATUS has only four count bits; a DEPTH=16 FIFO reports 15 when full.
  function automatic logic [3:0] sat_count4(input logic [4:0] cnt);
    return (cnt > 5'd15) ? 4'hF : cnt[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose: generic single-clock FIFO with count, synchronous flush and async active-low reset.
// Latency: push visible at dout/count the cycle after the push edge; dout is the combinational head.
// Backpressure: push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
// Ports: clk_i, rstn_i; push_i/pop_i/flush_i/din_i in; dout_o (head), count_o (0..DEPTH), full_o, empty_o out.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Flush wins over everything. A push into a full FIFO still lands when
  // the head leaves in the same cycle, because the slot it frees is reused.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/reg_bus_slave.sv
// Purpose: register bank (CTRL/STATUS/DATA/SCRATCH) on the 8-bit en/wr bus; DATA writes feed a FIFO drained as a byte stream.
// Latency: rdata one cycle after the read strobe; a pushed byte can appear on tx_data the cycle after the write.
// Backpressure: tx_valid held until tx_ready; DATA writes into a full FIFO are dropped and set sticky overflow.
// Ports: clk, rstn; bus en/wr/addr/wdata in, rdata out; stream tx_valid/tx_data out, tx_ready in;
//        irq out only when REG_BUS_SLAVE_IRQ_EN is defined (otherwise CTRL.irq_en is not stored).
module reg_bus_slave
  import reg_bus_pkg::*;
#(
  parameter int         DEPTH       = 8,
  parameter logic [7:0] SCRATCH_RST = 8'hA5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready
`ifdef REG_BUS_SLAVE_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  ctrl_t         ctrl_q, ctrl_d;
  logic [7:0]    scratch_q, scratch_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          ovf_q, ovf_d;

  logic          wr_acc, rd_acc;
  logic          ctrl_wr, stat_wr, data_wr, scr_wr;
  logic          fifo_push, fifo_pop, fifo_flush;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic [7:0]    status;

  assign wr_acc  = en & wr;
  assign rd_acc  = en & ~wr;
  assign ctrl_wr = wr_acc & (addr == ADDR_CTRL);
  assign stat_wr = wr_acc & (addr == ADDR_STATUS);
  assign data_wr = wr_acc & (addr == ADDR_DATA);
  assign scr_wr  = wr_acc & (addr == ADDR_SCRATCH);

  assign tx_valid   = ctrl_q.drain_en & ~fifo_empty;
  assign tx_data    = fifo_dout;
  assign fifo_pop   = tx_valid & tx_ready;
  assign fifo_push  = data_wr;
  // Flush is a pulse taken straight from the CTRL write; it is never stored.
  assign fifo_flush = ctrl_wr & wdata[CTRL_FLUSH];

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .din_i   (wdata),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Pre-edge view of the FIFO, so a STATUS read ignores this cycle's push/pop.
  always_comb begin
    status                              = '0;
    status[STAT_EMPTY]                  = fifo_empty;
    status[STAT_FULL]                   = fifo_full;
    status[STAT_OVERFLOW]               = ovf_q;
    status[STAT_CNT_LSB +: 4]           = sat_count4(5'(fifo_count));
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    ovf_d     = ovf_q;
    rdata_d   = rdata_q;

    if (ctrl_wr) begin
      ctrl_d          = '0;
      ctrl_d.drain_en = wdata[CTRL_DRAIN_EN];
`ifdef REG_BUS_SLAVE_IRQ_EN
      ctrl_d.irq_en   = wdata[CTRL_IRQ_EN];
`endif
    end

    if (scr_wr) scratch_d = wdata;

    // Clear first so a simultaneous overflow event wins. A push into a
    // full FIFO only overflows when no pop frees a slot that cycle.
    if (stat_wr && wdata[STAT_OVERFLOW]) ovf_d = 1'b0;
    if (fifo_push && fifo_full && !fifo_pop && !fifo_flush) ovf_d = 1'b1;

    if (rd_acc) begin
      case (addr)
        ADDR_CTRL:    rdata_d = ctrl_q;
        ADDR_STATUS:  rdata_d = status;
        ADDR_SCRATCH: rdata_d = scratch_q;
        default:      rdata_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q    <= '0;
      scratch_q <= SCRATCH_RST;
      ovf_q     <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata = rdata_q;

`ifdef REG_BUS_SLAVE_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = ctrl_q.irq_en & (ovf_q | (fifo_count >= CW'(DEPTH / 2)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_reg_bus_slave.sv
// Purpose: directed self-checking bench for reg_bus_slave (DEPTH=8, SCRATCH_RST=8'hA5).
// Latency: inputs driven at the falling edge, outputs compared at the following falling edge.
// Backpressure: tx_ready driven directly to exercise stall, pop and push+pop-when-full cases.
module tb_reg_bus_slave;

  logic       clk      = 1'b0;
  logic       rstn     = 1'b0;
  logic       en       = 1'b0;
  logic       wr       = 1'b0;
  logic [7:0] addr     = 8'h00;
  logic [7:0] wdata    = 8'h00;
  logic [7:0] rdata;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;
`ifdef REG_BUS_SLAVE_IRQ_EN
  logic       irq;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_bus_slave #(
    .DEPTH       (8),
    .SCRATCH_RST (8'hA5)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
`ifdef REG_BUS_SLAVE_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%02h exp=0x%02h", tag, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [7:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    en = 1'b0;
    check(tag, rdata, exp);
  endtask

  // Global bound: the bench never waits on a DUT event, but guard anyway.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench did not finish");
  end

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_rdata", rdata, 8'h00);
    rstn = 1'b1;

    rd_reg(8'h00, 8'h00, "rst_ctrl");
    rd_reg(8'h01, 8'h01, "rst_status");
    rd_reg(8'h03, 8'hA5, "rst_scratch");

    // SCRATCH and unmapped address
    wr_reg(8'h03, 8'h3C);
    rd_reg(8'h03, 8'h3C, "scratch_rw");
    wr_reg(8'h10, 8'hFF);
    rd_reg(8'h10, 8'h00, "unmapped_rd");
    rd_reg(8'h00, 8'h00, "unmapped_ctrl");
    rd_reg(8'h01, 8'h01, "unmapped_status");
    rd_reg(8'h03, 8'h3C, "unmapped_scratch");
    rd_reg(8'h02, 8'h00, "data_rd_zero");

    // Fill to full, then overflow
    for (int i = 1; i <= 8; i++) wr_reg(8'h02, 8'(i));
    rd_reg(8'h01, 8'h82, "status_full");
    check("full_no_valid", {7'b0, tx_valid}, 8'h00);
    wr_reg(8'h02, 8'h09);
    rd_reg(8'h01, 8'h86, "status_ovf");

    // Drain at full rate
    tx_ready = 1'b1;
    wr_reg(8'h00, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_vld%0d", i), {7'b0, tx_valid}, 8'h01);
      check($sformatf("drain_dat%0d", i), tx_data, 8'(i));
      @(negedge clk);
    end
    check("drain_done", {7'b0, tx_valid}, 8'h00);
    rd_reg(8'h01, 8'h05, "status_empty_ovf");
    wr_reg(8'h01, 8'h04);
    rd_reg(8'h01, 8'h01, "ovf_clear");

    // Push and pop in the same cycle while full
    wr_reg(8'h00, 8'h00);
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr_reg(8'h02, 8'(8'h11 + i));
    wr_reg(8'h00, 8'h01);
    check("pp_head", tx_data, 8'h11);
    check("pp_vld", {7'b0, tx_valid}, 8'h01);
    en = 1'b1; wr = 1'b1; addr = 8'h02; wdata = 8'h19; tx_ready = 1'b1;
    @(negedge clk);
    en = 1'b0; wr = 1'b0; tx_ready = 1'b0;
    rd_reg(8'h01, 8'h82, "pp_status");
    check("pp_head2", tx_data, 8'h12);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pp_dat%0d", i), tx_data, 8'(8'h12 + i));
      @(negedge clk);
    end
    check("pp_done", {7'b0, tx_valid}, 8'h00);

    // Flush
    wr_reg(8'h00, 8'h00);
    for (int i = 0; i < 3; i++) wr_reg(8'h02, 8'(8'h21 + i));
    rd_reg(8'h01, 8'h30, "pre_flush");
    check("stall_no_valid", {7'b0, tx_valid}, 8'h00);
    wr_reg(8'h00, 8'h04);
    rd_reg(8'h01, 8'h01, "post_flush");
    rd_reg(8'h00, 8'h00, "flush_rd0");

    // Reset mid-stream
    wr_reg(8'h03, 8'h5A);
    rd_reg(8'h03, 8'h5A, "scratch2");
    for (int i = 0; i < 3; i++) wr_reg(8'h02, 8'(8'h31 + i));
    wr_reg(8'h00, 8'h01);
    check("ms_dat0", tx_data, 8'h31);
    @(negedge clk);
    check("ms_dat1", tx_data, 8'h32);
    #2 rstn = 1'b0;
    #1;
    check("ms_rst_vld", {7'b0, tx_valid}, 8'h00);
    check("ms_rst_dat", tx_data, 8'h00);
    check("ms_rst_rdata", rdata, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    tx_ready = 1'b0;
    rd_reg(8'h03, 8'hA5, "ms_scratch");
    rd_reg(8'h01, 8'h01, "ms_status");
    rd_reg(8'h00, 8'h00, "ms_ctrl");

`ifdef REG_BUS_SLAVE_IRQ_EN
    // irq at half full, registered
    wr_reg(8'h00, 8'h02);
    rd_reg(8'h00, 8'h02, "irq_ctrl");
    for (int i = 0; i < 3; i++) wr_reg(8'h02, 8'(8'h41 + i));
    @(negedge clk);
    check("irq_below", {7'b0, irq}, 8'h00);
    wr_reg(8'h02, 8'h44);
    @(negedge clk);
    check("irq_half", {7'b0, irq}, 8'h01);
    wr_reg(8'h00, 8'h06);
    @(negedge clk);
    check("irq_clear", {7'b0, irq}, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
